// File: rtl/unpacker_pkg.sv
// Shared definitions for the SRAM-to-PE-array unpacking read path:
// lane count, lane/word width relation and the reader FSM states.
package unpacker_pkg;

  localparam int LANES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A word must split into exactly LANES lanes of lane_w bits.
  function automatic bit lane_cfg_ok(input int lane_w, input int mem_bw);
    return (lane_w > 0) && (mem_bw == LANES * lane_w);
  endfunction

endpackage

// File: rtl/unpacker_fifo2.sv
// Two-entry first-word-fall-through register FIFO; the head entry is
// always visible on dout and a push becomes visible the cycle after.
module unpacker_fifo2 #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && (count_reg != 2'd0);
  assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop_ok) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == 2'd0);
  assign full  = (count_reg == 2'd2);

endmodule

// File: rtl/unpacker_reader.sv
// Streams a run of SRAM words into a 2-entry FWFT buffer and presents each
// word downstream as 16 lanes over valid/ready, one word per cycle when ready.
module unpacker_reader
  import unpacker_pkg::*;
#(
  parameter int IO_DATA_WIDTH = 8,
  parameter int MEM_BW        = 128,
  parameter int ADDR_WIDTH    = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [CNT_WIDTH-1:0]           num_words,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_re,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [MEM_BW-1:0]              mem_rdata,
  output logic [LANES*IO_DATA_WIDTH-1:0] inputs_out,
  output logic                           out_valid,
  input  logic                           out_ready
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [CNT_WIDTH-1:0]  total_reg;
  logic [CNT_WIDTH-1:0]  issued_reg;
  logic [CNT_WIDTH-1:0]  delivered_reg;
  logic                  inflight_reg;
  logic                  zero_done_reg;

  logic [MEM_BW-1:0]     fifo_head;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  issue;
  logic                  credit_ok;
  logic                  accept;
  logic                  accept_zero;
  logic                  last_issue;
  logic                  drain_done;
  logic [2:0]            occ_after;

  assign pop         = !fifo_empty && out_ready;
  assign accept      = (state_reg == IDLE) && start && (num_words != '0);
  assign accept_zero = (state_reg == IDLE) && start && (num_words == '0);

  // Occupancy once this cycle's pop leaves and the in-flight word lands;
  // counting the pop lets a new read go out every cycle while draining.
  assign occ_after  = {1'b0, fifo_count} + {2'b0, inflight_reg} - {2'b0, pop};
  assign credit_ok  = (occ_after < 3'd2) && !(fifo_full && !pop);
  assign issue      = (state_reg == READ) && credit_ok;
  assign last_issue = issue && ((issued_reg + CNT_WIDTH'(1)) == total_reg);
  assign drain_done = (state_reg == DRAIN) && fifo_empty && !inflight_reg &&
                      (delivered_reg == total_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = READ;
      READ:    if (last_issue) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != IDLE);
    done     = drain_done || zero_done_reg;
    mem_re   = issue;
    mem_addr = '0;
    if (issue) begin
      mem_addr = addr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      total_reg     <= '0;
      issued_reg    <= '0;
      delivered_reg <= '0;
      inflight_reg  <= 1'b0;
      zero_done_reg <= 1'b0;
    end else begin
      inflight_reg  <= issue;
      zero_done_reg <= accept_zero;
      if (accept) begin
        addr_reg      <= base_addr;
        total_reg     <= num_words;
        issued_reg    <= '0;
        delivered_reg <= '0;
      end else begin
        if (issue) begin
          addr_reg   <= addr_reg + ADDR_WIDTH'(1);
          issued_reg <= issued_reg + CNT_WIDTH'(1);
        end
        if (pop) begin
          delivered_reg <= delivered_reg + CNT_WIDTH'(1);
        end
      end
    end
  end

  // The SRAM word returns exactly one cycle after mem_re, so it is pushed
  // on the in-flight flag alone; reset clearing the flag drops a stale return.
  unpacker_fifo2 #(
    .WIDTH (MEM_BW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_reg),
    .pop   (pop),
    .din   (mem_rdata),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = !fifo_empty;

  if (lane_cfg_ok(IO_DATA_WIDTH, MEM_BW)) begin : g_lanes
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign inputs_out[gi*IO_DATA_WIDTH +: IO_DATA_WIDTH] =
        fifo_head[gi*IO_DATA_WIDTH +: IO_DATA_WIDTH];
    end
  end else begin : g_cfg_bad
    assign inputs_out = '0;
  end

endmodule

// File: tb/tb_unpacker_reader.sv
// Directed bench for unpacker_reader: SRAM model, queue-based reference of
// issue/delivery behaviour checked every cycle, plus literal spot checks.
module tb_unpacker_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  num_words = '0;
  logic         busy, done, mem_re, out_valid;
  logic [15:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic [127:0] inputs_out;
  logic         out_ready = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  unpacker_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .inputs_out (inputs_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM content: lane i of word a is low byte of a*16+i, lane 15 also xor a[15:8].
  function automatic logic [127:0] word_at(input logic [15:0] a);
    logic [127:0] w;
    logic [7:0]   b;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b = 8'((32'(a) * 16) + i);
      if (i == 15) b = b ^ a[15:8];
      w[i*8 +: 8] = b;
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= word_at(mem_addr);
    else        mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  int           rd_left = 0;
  logic [15:0]  nxt_addr = '0;
  int           rd_cyc_q[$];
  logic [127:0] exp_data_q[$];

  // Observation logs for directed checks
  logic [15:0]  addr_log[$];
  int           re_cyc_log[$];
  int           hs_cyc_log[$];
  logic [127:0] hs_data_log[$];
  int           done_cyc = 0;
  int           done_cnt = 0;

  always @(negedge clk) begin
    logic exp_valid, exp_hs, exp_re, nxt_busy, nxt_done;
    if (rst) begin
      rd_cyc_q.delete();
      exp_data_q.delete();
      exp_busy = 1'b0;
      exp_done = 1'b0;
      rd_left  = 0;
    end else begin
      exp_valid = (rd_cyc_q.size() > 0) && (rd_cyc_q[0] + 2 <= cyc);
      exp_hs    = exp_valid && out_ready;
      exp_re    = exp_busy && (rd_left > 0) && ((rd_cyc_q.size() - int'(exp_hs)) < 2);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) chk("inputs_out", inputs_out, exp_data_q[0]);
      chk("mem_re", mem_re, exp_re);
      if (exp_re) chk("mem_addr", mem_addr, nxt_addr);

      if (mem_re) begin
        addr_log.push_back(mem_addr);
        re_cyc_log.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        hs_cyc_log.push_back(cyc);
        hs_data_log.push_back(inputs_out);
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end

      nxt_done = 1'b0;
      nxt_busy = exp_busy && !exp_done;
      if (exp_re) begin
        rd_cyc_q.push_back(cyc);
        nxt_addr = nxt_addr + 16'd1;
        rd_left--;
      end
      if (exp_hs) begin
        void'(rd_cyc_q.pop_front());
        void'(exp_data_q.pop_front());
        if (exp_data_q.size() == 0 && rd_left == 0) nxt_done = 1'b1;
      end
      if (start && !exp_busy) begin
        if (num_words == 16'd0) begin
          nxt_done = 1'b1;
        end else begin
          nxt_busy = 1'b1;
          rd_left  = int'(num_words);
          nxt_addr = base_addr;
          for (int i = 0; i < int'(num_words); i++)
            exp_data_q.push_back(word_at(base_addr + 16'(i)));
        end
      end
      exp_busy = nxt_busy;
      exp_done = nxt_done;
    end
  end

  // Downstream ready: always high, or the 1,0,0 repeating pattern.
  logic bp_mode = 1'b0;
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  int s_cyc = 0;

  task automatic clear_logs();
    addr_log.delete();
    re_cyc_log.delete();
    hs_cyc_log.delete();
    hs_data_log.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    @(posedge clk);
    #1;
    clear_logs();
    start = 1'b1;
    base_addr = b;
    num_words = n;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done_cnt != 0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_mem_re"}, mem_re, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_inputs_out"}, inputs_out, 128'h0);
  endtask

  initial begin
    logic [127:0] w;
    int n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Single word
    do_start(16'h0010, 16'd1);
    wait_done(50);
    chk("single_reads", addr_log.size(), 1);
    chk("single_beats", hs_cyc_log.size(), 1);
    if (addr_log.size() > 0) begin
      chk("single_addr", addr_log[0], 16'h0010);
      chk("single_re_lat", re_cyc_log[0] - s_cyc, 1);
    end
    if (hs_cyc_log.size() > 0) begin
      w = hs_data_log[0];
      chk("single_valid_lat", hs_cyc_log[0] - s_cyc, 3);
      chk("single_word", w, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("single_lane0", w[7:0], 8'h00);
      chk("single_lane15", w[127:120], 8'h0F);
      chk("single_done_lat", done_cyc - hs_cyc_log[0], 1);
    end
    chk("single_done_cnt", done_cnt, 1);

    // Streaming at full rate
    do_start(16'h0100, 16'd8);
    wait_done(60);
    chk("stream_reads", addr_log.size(), 8);
    chk("stream_beats", hs_cyc_log.size(), 8);
    if (addr_log.size() == 8) begin
      chk("stream_re_span", re_cyc_log[7] - re_cyc_log[0], 7);
      chk("stream_addr_last", addr_log[7], 16'h0107);
    end
    if (hs_cyc_log.size() == 8) begin
      chk("stream_beat_span", hs_cyc_log[7] - hs_cyc_log[0], 7);
      chk("stream_done_lat", done_cyc - hs_cyc_log[7], 1);
    end

    // Backpressure
    bp_mode = 1'b1;
    do_start(16'h0040, 16'd6);
    wait_done(120);
    bp_mode = 1'b0;
    chk("bp_reads", addr_log.size(), 6);
    chk("bp_beats", hs_cyc_log.size(), 6);
    chk("bp_done_cnt", done_cnt, 1);

    // Zero length
    do_start(16'h0500, 16'd0);
    repeat (3) @(negedge clk);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_done_lat", done_cyc - s_cyc, 1);
    chk("zero_reads", addr_log.size(), 0);

    // Start while busy is ignored
    do_start(16'h0200, 16'd4);
    start = 1'b1;
    base_addr = 16'h0300;
    num_words = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60);
    chk("busy_start_beats", hs_cyc_log.size(), 4);
    chk("busy_start_reads", addr_log.size(), 4);
    chk("busy_start_done_cnt", done_cnt, 1);
    if (addr_log.size() == 4) chk("busy_start_addr3", addr_log[3], 16'h0203);

    // Address wrap
    do_start(16'hFFFE, 16'd4);
    wait_done(60);
    chk("wrap_reads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wrap_addr0", addr_log[0], 16'hFFFE);
      chk("wrap_addr1", addr_log[1], 16'hFFFF);
      chk("wrap_addr2", addr_log[2], 16'h0000);
      chk("wrap_addr3", addr_log[3], 16'h0001);
    end

    // Reset mid-run
    do_start(16'h0400, 16'd10);
    n = 0;
    while (hs_cyc_log.size() < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_progress", hs_cyc_log.size() >= 3, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_beats", hs_cyc_log.size(), 0);
    chk("midrst_no_reads", addr_log.size(), 0);

    do_start(16'h0600, 16'd2);
    wait_done(50);
    chk("after_rst_beats", hs_cyc_log.size(), 2);
    chk("after_rst_done_cnt", done_cnt, 1);
    if (hs_data_log.size() == 2) chk("after_rst_word1", hs_data_log[1], word_at(16'h0601));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
